uart_axil_bridge: RTL
=====================

# uart_axil_bridge

AXI4-Lite slave adapter that sits directly upstream of the simulation UART in `simtop`. It converts core-side AXI4-Lite read and write transactions into the UART's single-cycle `rvalid`/`wvalid` strobe interface. It also returns the UART's combinational `rdata` as an AXI R beat. Reads and writes run in independent state machines, with one outstanding transaction per direction.

## Interface
- `SERIAL_PORT`, default 32'ha00003f8: UART data register address. It must match the downstream UART's parameter.
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `s_araddr` in 32, `s_arvalid` in 1, `s_arready` out 1: AR channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: R channel.
- `s_awaddr` in 32, `s_awvalid` in 1, `s_awready` out 1: AW channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: W channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: B channel.
- `raddr` out 32, `rvalid` out 1, `rdata` in 32: UART read port. `rvalid` is a one-cycle pop strobe.
- `waddr` out 32, `wdata` out 32, `wvalid` out 1: UART write port. `wvalid` is a one-cycle push strobe.

## Operation
- Address match: `hit = addr[31:2] == SERIAL_PORT[31:2]`. On a hit, `raddr`/`waddr` are driven to `SERIAL_PORT`; otherwise they are driven to 0.
- Read FSM states are R_IDLE, R_ISSUE and R_RESP.
  - R_IDLE: `s_arready`=1. On an AR handshake, latch the address and go to R_ISSUE.
  - R_ISSUE, lasting exactly 1 cycle: `rvalid` = hit. Capture `rdata` into the R data register, or 32'h0 on a miss. Capture `s_rresp` as 2'b00 on a hit, 2'b11 (DECERR) on a miss. Go to R_RESP.
  - R_RESP: `s_rvalid`=1, with data and resp held stable. On `s_rready`, go to R_IDLE.
- Write FSM states are W_IDLE, W_ISSUE and W_RESP.
  - W_IDLE: `s_awready` = !aw_got and `s_wready` = !w_got. AW and W are accepted in either order or in the same cycle. Each is latched, and its flag is set.
  - When both flags are set, go to W_ISSUE on the next cycle.
  - W_ISSUE, lasting 1 cycle: `wvalid` = hit && strobe_ok, and `wdata` = latched data. Flags clear. Go to W_RESP.
  - W_RESP: `s_bvalid`=1. `s_bresp` is 2'b00 on a hit and 2'b11 on a miss. On `s_bready`, go to W_IDLE.
- The UART silently drops pushes when its TX FIFO is full. The bridge still returns OKAY and applies no backpressure.
- The UART returns 32'hff when its RX FIFO is empty. The bridge passes this value through unchanged.
- Read and write FSMs are fully independent. Simultaneous `rvalid` and `wvalid` in the same cycle are legal.

## Timing
- Reset values:
  - `s_arready`=0, `s_awready`=0, `s_wready`=0.
  - `s_rvalid`=0, `s_bvalid`=0.
  - `rvalid`=0, `wvalid`=0.
  - `s_rdata`=0, `s_rresp`=0, `s_bresp`=0.
  - `raddr`=0, `waddr`=0, `wdata`=0.
  - Both FSMs start in IDLE with flags cleared. The ready signals rise on the first cycle after reset deasserts.
- Read latency is 2 cycles: AR handshake in cycle N, `rvalid` in N+1, `s_rvalid` in N+2.
- Write latency: if the later of AW/W handshakes occurs in cycle N, `wvalid` is in N+1 and `s_bvalid` is in N+2.
- `rvalid`/`wvalid` are asserted for exactly one cycle per transaction. They are never repeated while R or B is stalled by `s_rready`=0 or `s_bready`=0.
- `s_arready`=0 outside R_IDLE. `s_awready`/`s_wready`=0 outside W_IDLE.
- Reset asserted mid-transaction aborts both FSMs to IDLE on the next edge. The pending response is discarded and no strobe fires.

## Configuration
- `UART_BRIDGE_WSTRB_EN`:
  - Defined: strobe_ok = `s_wstrb[0]`. A write with `wstrb[0]`=0 produces no `wvalid` but still completes with OKAY.
  - Undefined: strobe_ok = 1. `s_wstrb` is ignored, and every hit write pushes `wdata[7:0]`.

## Test plan
- Read with the UART RX FIFO empty: AR at 32'ha00003f8 -> one `rvalid` pulse, then R beat with `s_rdata`=32'hff and `s_rresp`=00.
- Write 32'h41 with W arriving 3 cycles before AW -> exactly one `wvalid` pulse with `wdata`=32'h41, B with OKAY, and a UART `tx` frame carrying 0x41.
- AR at 32'h10000000 and AW at 32'h10000000 -> no `rvalid`/`wvalid`, `s_rresp`=11, `s_bresp`=11, `s_rdata`=0.
- `s_rready` held low for 10 cycles after a read -> `s_rvalid` and data stay stable, a single `rvalid` pulse only, `s_arready`=0 throughout.
- Reset asserted in R_RESP and in W_ISSUE -> all outputs return to reset values on the next edge, and no further strobe fires.
- With `UART_BRIDGE_WSTRB_EN` defined, a write with `wstrb`=4'b1110 -> no `wvalid`, B OKAY. With the macro undefined, the same write -> one `wvalid`.

Source files
------------

// File: rtl/uart_axil_bridge.sv
// uart_axil_bridge
//   AXI4-Lite slave that fronts the simulation UART. Core-side AR/R and AW/W/B
//   transactions are turned into the UART's one-cycle rvalid/wvalid strobes.
//   Reads and writes use independent FSMs, one outstanding transaction each.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   s_ar*/s_r*              : AXI4-Lite read address / read data channels
//   s_aw*/s_w*/s_b*         : AXI4-Lite write address / data / response channels
//   raddr, rvalid, rdata    : UART read port (rvalid = one-cycle pop strobe)
//   waddr, wdata, wvalid    : UART write port (wvalid = one-cycle push strobe)
//
// Build option
//   UART_BRIDGE_WSTRB_EN : when defined, a write only pushes if s_wstrb[0] is
//                          set; otherwise s_wstrb is ignored.
module uart_axil_bridge #(
   parameter logic [31:0] SERIAL_PORT = 32'ha00003f8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   output logic [31:0] raddr,
   output logic        rvalid,
   input  logic [31:0] rdata,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        wvalid
);

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_ISSUE = 2'd1;
   localparam logic [1:0] R_RESP  = 2'd2;
   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_ISSUE = 2'd1;
   localparam logic [1:0] W_RESP  = 2'd2;

   function automatic logic addr_hit(input logic [29:0] word_addr);
      return word_addr == SERIAL_PORT[31:2];
   endfunction

   logic strobe_ok;
`ifdef UART_BRIDGE_WSTRB_EN
   assign strobe_ok = s_wstrb[0];
`else
   assign strobe_ok = 1'b1;
`endif

   // Byte-offset bits never take part in decode.
   logic unused_bits;
   assign unused_bits = ^{s_araddr[1:0], s_awaddr[1:0], s_wstrb};

   // Read side state
   logic [1:0]  rstate_q, rstate_d;
   logic        ar_hit_q, ar_hit_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] raddr_q, raddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   // Write side state
   logic [1:0]  wstate_q, wstate_d;
   logic        aw_got_q, aw_got_d;
   logic        w_got_q, w_got_d;
   logic        aw_hit_q, aw_hit_d;
   logic        w_ok_q, w_ok_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        wvalid_q, wvalid_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  bresp_q, bresp_d;

   always_comb begin
      rstate_d = rstate_q;
      ar_hit_d = ar_hit_q;
      raddr_d  = raddr_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rvalid_d = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (s_arvalid && arready_q) begin
               ar_hit_d = addr_hit(s_araddr[31:2]);
               rvalid_d = ar_hit_d;
               raddr_d  = ar_hit_d ? SERIAL_PORT : 32'h0;
               rstate_d = R_ISSUE;
            end
         end
         R_ISSUE: begin
            // UART rdata is combinational on raddr while the pop strobe is high.
            rdata_d  = ar_hit_q ? rdata : 32'h0;
            rresp_d  = ar_hit_q ? 2'b00 : 2'b11;
            rstate_d = R_RESP;
         end
         R_RESP: begin
            if (s_rready) rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
      // Ready is registered so it stays low while reset is held.
      arready_d = (rstate_d == R_IDLE);
   end

   always_comb begin
      wstate_d = wstate_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      aw_hit_d = aw_hit_q;
      w_ok_d   = w_ok_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      bresp_d  = bresp_q;
      wvalid_d = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (s_awvalid && awready_q) begin
               aw_got_d = 1'b1;
               aw_hit_d = addr_hit(s_awaddr[31:2]);
            end
            if (s_wvalid && wready_q) begin
               w_got_d = 1'b1;
               wdata_d = s_wdata;
               w_ok_d  = strobe_ok;
            end
            // Both halves present (possibly just arrived): issue next cycle.
            if (aw_got_d && w_got_d) begin
               wvalid_d = aw_hit_d && w_ok_d;
               waddr_d  = aw_hit_d ? SERIAL_PORT : 32'h0;
               bresp_d  = aw_hit_d ? 2'b00 : 2'b11;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               wstate_d = W_ISSUE;
            end
         end
         W_ISSUE: wstate_d = W_RESP;
         W_RESP: begin
            if (s_bready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
      awready_d = (wstate_d == W_IDLE) && !aw_got_d;
      wready_d  = (wstate_d == W_IDLE) && !w_got_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rstate_q  <= R_IDLE;
         ar_hit_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         raddr_q   <= 32'h0;
         rdata_q   <= 32'h0;
         rresp_q   <= 2'b00;
         wstate_q  <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         aw_hit_q  <= 1'b0;
         w_ok_q    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         wvalid_q  <= 1'b0;
         waddr_q   <= 32'h0;
         wdata_q   <= 32'h0;
         bresp_q   <= 2'b00;
      end else begin
         rstate_q  <= rstate_d;
         ar_hit_q  <= ar_hit_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         raddr_q   <= raddr_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         wstate_q  <= wstate_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         aw_hit_q  <= aw_hit_d;
         w_ok_q    <= w_ok_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         wvalid_q  <= wvalid_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         bresp_q   <= bresp_d;
      end
   end

   assign s_arready = arready_q;
   assign s_rvalid  = (rstate_q == R_RESP);
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign rvalid    = rvalid_q;
   assign raddr     = raddr_q;
   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = (wstate_q == W_RESP);
   assign s_bresp   = bresp_q;
   assign wvalid    = wvalid_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;

endmodule
